// File: rtl/sid_pkg.sv
// Shared register-map constants and the per-voice register struct for the SID register bank.
package sid_pkg;

  localparam int NUM_VOICES   = 3;
  localparam int VOICE_STRIDE = 7;

  localparam logic [2:0] OFF_FREQ_LO = 3'd0;
  localparam logic [2:0] OFF_FREQ_HI = 3'd1;
  localparam logic [2:0] OFF_PW_LO   = 3'd2;
  localparam logic [2:0] OFF_PW_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL    = 3'd4;
  localparam logic [2:0] OFF_AD      = 3'd5;
  localparam logic [2:0] OFF_SR      = 3'd6;

  localparam logic [6:0] ADDR_FC_LO    = 7'h15;
  localparam logic [6:0] ADDR_FC_HI    = 7'h16;
  localparam logic [6:0] ADDR_RES_FILT = 7'h17;
  localparam logic [6:0] ADDR_MODE_VOL = 7'h18;
  localparam logic [6:0] ADDR_OSC3     = 7'h1B;
  localparam logic [6:0] ADDR_ENV3     = 7'h1C;

  typedef struct packed {
    logic [15:0] freq;
    logic [11:0] pw;
    logic [7:0]  ctrl;
    logic [7:0]  ad;
    logic [7:0]  sr;
  } voice_regs_t;

endpackage

// File: rtl/sid_voice_regs.sv
// One voice: pending LO bytes, shadow registers, tick-updated live copy and gate edge pulses.
module sid_voice_regs
  import sid_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_we,
  input  logic [2:0]  i_off,
  input  logic [7:0]  i_wdata,
  input  logic        i_tick,
  output logic [7:0]  o_rdata,
  output voice_regs_t o_live,
  output logic        o_gate_rise,
  output logic        o_gate_fall
);

  logic [7:0]  r_freq_lo_pend;
  logic [7:0]  r_pw_lo_pend;
  voice_regs_t r_shadow;
  voice_regs_t r_live;
  logic        r_gate_rise;
  logic        r_gate_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_freq_lo_pend <= '0;
      r_pw_lo_pend   <= '0;
      r_shadow       <= '0;
      r_live         <= '0;
      r_gate_rise    <= 1'b0;
      r_gate_fall    <= 1'b0;
    end else begin
      // Live copy samples the shadow before this cycle's write lands.
      r_gate_rise <= 1'b0;
      r_gate_fall <= 1'b0;
      if (i_tick) begin
        r_live      <= r_shadow;
        r_gate_rise <= r_shadow.ctrl[0] & ~r_live.ctrl[0];
        r_gate_fall <= ~r_shadow.ctrl[0] & r_live.ctrl[0];
      end
      if (i_we) begin
        case (i_off)
          OFF_FREQ_LO: r_freq_lo_pend  <= i_wdata;
          OFF_FREQ_HI: r_shadow.freq   <= {i_wdata, r_freq_lo_pend};
          OFF_PW_LO:   r_pw_lo_pend    <= i_wdata;
          OFF_PW_HI:   r_shadow.pw     <= {i_wdata[3:0], r_pw_lo_pend};
          OFF_CTRL:    r_shadow.ctrl   <= i_wdata;
          OFF_AD:      r_shadow.ad     <= i_wdata;
          OFF_SR:      r_shadow.sr     <= i_wdata;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    o_rdata = 8'h00;
    case (i_off)
      OFF_FREQ_LO: o_rdata = r_freq_lo_pend;
      OFF_FREQ_HI: o_rdata = r_shadow.freq[15:8];
      OFF_PW_LO:   o_rdata = r_pw_lo_pend;
      OFF_PW_HI:   o_rdata = {4'b0000, r_shadow.pw[11:8]};
      OFF_CTRL:    o_rdata = r_shadow.ctrl;
      OFF_AD:      o_rdata = r_shadow.ad;
      OFF_SR:      o_rdata = r_shadow.sr;
      default:     o_rdata = 8'h00;
    endcase
  end

  assign o_live      = r_live;
  assign o_gate_rise = r_gate_rise;
  assign o_gate_fall = r_gate_fall;

endmodule

// File: rtl/sid_regs.sv
// SID register bank top: address decode, filter registers, read mux and three voice instances.
module sid_regs
  import sid_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       reg_addr_i,
  input  logic [7:0]       reg_wdata_i,
  input  logic             reg_we_i,
  output logic [7:0]       reg_rdata_o,
  input  logic             sample_tick_i,
  input  logic [7:0]       osc3_i,
  input  logic [7:0]       env3_i,
  output logic [2:0][15:0] freq_o,
  output logic [2:0][11:0] pw_o,
  output logic [2:0][7:0]  ctrl_o,
  output logic [2:0][7:0]  ad_o,
  output logic [2:0][7:0]  sr_o,
  output logic [2:0]       gate_rise_o,
  output logic [2:0]       gate_fall_o,
  output logic [10:0]      fc_o,
  output logic [7:0]       res_filt_o,
  output logic [7:0]       mode_vol_o
);

  logic        w_vhit;
  logic [1:0]  w_vsel;
  logic [2:0]  w_voff;
  logic [7:0]  w_rdata;
  logic [7:0]  w_vrdata [NUM_VOICES];
  voice_regs_t w_live   [NUM_VOICES];

  logic [2:0]  r_fc_lo_pend;
  logic [10:0] r_fc_shadow;
  logic [7:0]  r_res_shadow;
  logic [7:0]  r_mv_shadow;
  logic [10:0] r_fc_live;
  logic [7:0]  r_res_live;
  logic [7:0]  r_mv_live;
  logic [7:0]  r_rdata;

  always_comb begin
    w_vhit = 1'b1;
    w_vsel = 2'd0;
    w_voff = reg_addr_i[2:0];
    if (reg_addr_i < 7'(VOICE_STRIDE)) begin
      w_vsel = 2'd0;
    end else if (reg_addr_i < 7'(2 * VOICE_STRIDE)) begin
      w_vsel = 2'd1;
      w_voff = 3'(reg_addr_i - 7'(VOICE_STRIDE));
    end else if (reg_addr_i < 7'(3 * VOICE_STRIDE)) begin
      w_vsel = 2'd2;
      w_voff = 3'(reg_addr_i - 7'(2 * VOICE_STRIDE));
    end else begin
      w_vhit = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    sid_voice_regs u_voice (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_we        (reg_we_i && w_vhit && (w_vsel == 2'(gi))),
      .i_off       (w_voff),
      .i_wdata     (reg_wdata_i),
      .i_tick      (sample_tick_i),
      .o_rdata     (w_vrdata[gi]),
      .o_live      (w_live[gi]),
      .o_gate_rise (gate_rise_o[gi]),
      .o_gate_fall (gate_fall_o[gi])
    );
    assign freq_o[gi] = w_live[gi].freq;
    assign pw_o[gi]   = w_live[gi].pw;
    assign ctrl_o[gi] = w_live[gi].ctrl;
    assign ad_o[gi]   = w_live[gi].ad;
    assign sr_o[gi]   = w_live[gi].sr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fc_lo_pend <= '0;
      r_fc_shadow  <= '0;
      r_res_shadow <= '0;
      r_mv_shadow  <= '0;
      r_fc_live    <= '0;
      r_res_live   <= '0;
      r_mv_live    <= '0;
    end else begin
      if (sample_tick_i) begin
        r_fc_live  <= r_fc_shadow;
        r_res_live <= r_res_shadow;
        r_mv_live  <= r_mv_shadow;
      end
      if (reg_we_i) begin
        case (reg_addr_i)
          ADDR_FC_LO:    r_fc_lo_pend <= reg_wdata_i[2:0];
          ADDR_FC_HI:    r_fc_shadow  <= {reg_wdata_i, r_fc_lo_pend};
          ADDR_RES_FILT: r_res_shadow <= reg_wdata_i;
          ADDR_MODE_VOL: r_mv_shadow  <= reg_wdata_i;
          default:       ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    if (w_vhit) begin
      w_rdata = w_vrdata[w_vsel];
    end else begin
      case (reg_addr_i)
        ADDR_FC_LO:    w_rdata = {5'b00000, r_fc_lo_pend};
        ADDR_FC_HI:    w_rdata = r_fc_shadow[10:3];
        ADDR_RES_FILT: w_rdata = r_res_shadow;
        ADDR_MODE_VOL: w_rdata = r_mv_shadow;
        ADDR_OSC3:     w_rdata = osc3_i;
        ADDR_ENV3:     w_rdata = env3_i;
        default:       w_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= 8'h00;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign reg_rdata_o = r_rdata;
  assign fc_o        = r_fc_live;
  assign res_filt_o  = r_res_live;
  assign mode_vol_o  = r_mv_live;

endmodule

// File: tb/tb_sid_regs.sv
// Self-checking bench for sid_regs: byte-level register-map model plus directed and random stimulus.
module tb_sid_regs;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [6:0]       reg_addr_i = '0;
  logic [7:0]       reg_wdata_i = '0;
  logic             reg_we_i = 1'b0;
  logic [7:0]       reg_rdata_o;
  logic             sample_tick_i = 1'b0;
  logic [7:0]       osc3_i = '0;
  logic [7:0]       env3_i = '0;
  logic [2:0][15:0] freq_o;
  logic [2:0][11:0] pw_o;
  logic [2:0][7:0]  ctrl_o;
  logic [2:0][7:0]  ad_o;
  logic [2:0][7:0]  sr_o;
  logic [2:0]       gate_rise_o;
  logic [2:0]       gate_fall_o;
  logic [10:0]      fc_o;
  logic [7:0]       res_filt_o;
  logic [7:0]       mode_vol_o;

  sid_regs dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .reg_addr_i    (reg_addr_i),
    .reg_wdata_i   (reg_wdata_i),
    .reg_we_i      (reg_we_i),
    .reg_rdata_o   (reg_rdata_o),
    .sample_tick_i (sample_tick_i),
    .osc3_i        (osc3_i),
    .env3_i        (env3_i),
    .freq_o        (freq_o),
    .pw_o          (pw_o),
    .ctrl_o        (ctrl_o),
    .ad_o          (ad_o),
    .sr_o          (sr_o),
    .gate_rise_o   (gate_rise_o),
    .gate_fall_o   (gate_fall_o),
    .fc_o          (fc_o),
    .res_filt_o    (res_filt_o),
    .mode_vol_o    (mode_vol_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: one byte per register address 0x00..0x18 for shadow, pending and live.
  logic [7:0] m_sh   [0:31];
  logic [7:0] m_pend [0:31];
  logic [7:0] m_live [0:31];
  logic [7:0] m_rdata;
  logic [2:0] m_rise, m_fall;
  bit         chk_en = 1'b0;

  function automatic bit is_lo(input int a);
    return (a < 21 && (a % 7 == 0 || a % 7 == 2)) || a == 21;
  endfunction

  function automatic bit is_hi(input int a);
    return (a < 21 && (a % 7 == 1 || a % 7 == 3)) || a == 22;
  endfunction

  function automatic logic [7:0] wmask(input int a);
    if (a < 21 && a % 7 == 3) return 8'h0F;
    if (a == 21) return 8'h07;
    return 8'hFF;
  endfunction

  function automatic logic [7:0] m_read(input int a);
    if (a == 27) return osc3_i;
    if (a == 28) return env3_i;
    if (a > 24) return 8'h00;
    if (is_lo(a)) return m_pend[a];
    return m_sh[a];
  endfunction

  always @(posedge clk_i) begin
    int a;
    logic o, n;
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        m_sh[i] = 8'h00; m_pend[i] = 8'h00; m_live[i] = 8'h00;
      end
      m_rdata = 8'h00; m_rise = '0; m_fall = '0;
      chk_en = 1'b1;
    end else begin
      a = int'(reg_addr_i);
      m_rdata = m_read(a);
      m_rise = '0; m_fall = '0;
      if (sample_tick_i) begin
        for (int v = 0; v < 3; v++) begin
          o = m_live[7*v+4][0];
          n = m_sh[7*v+4][0];
          m_rise[v] = n & ~o;
          m_fall[v] = o & ~n;
        end
        for (int i = 0; i < 32; i++) m_live[i] = m_sh[i];
      end
      if (reg_we_i && a <= 24) begin
        if (is_lo(a)) m_pend[a] = reg_wdata_i & wmask(a);
        else if (is_hi(a)) begin
          m_sh[a]   = reg_wdata_i & wmask(a);
          m_sh[a-1] = m_pend[a-1];
        end else m_sh[a] = reg_wdata_i;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("rdata", reg_rdata_o, m_rdata);
      chk("gate_rise", gate_rise_o, m_rise);
      chk("gate_fall", gate_fall_o, m_fall);
      for (int v = 0; v < 3; v++) begin
        chk($sformatf("freq%0d", v), freq_o[v], {m_live[7*v+1], m_live[7*v]});
        chk($sformatf("pw%0d", v), pw_o[v], {m_live[7*v+3][3:0], m_live[7*v+2]});
        chk($sformatf("ctrl%0d", v), ctrl_o[v], m_live[7*v+4]);
        chk($sformatf("ad%0d", v), ad_o[v], m_live[7*v+5]);
        chk($sformatf("sr%0d", v), sr_o[v], m_live[7*v+6]);
      end
      chk("fc", fc_o, {m_live[22], m_live[21][2:0]});
      chk("res_filt", res_filt_o, m_live[23]);
      chk("mode_vol", mode_vol_o, m_live[24]);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    reg_addr_i = a; reg_wdata_i = d; reg_we_i = 1'b1;
    cyc();
    reg_we_i = 1'b0;
    $display("wr addr=%h data=%h", a, d);
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] v);
    reg_addr_i = a;
    cyc();
    v = reg_rdata_o;
  endtask

  task automatic tick();
    sample_tick_i = 1'b1;
    cyc();
    sample_tick_i = 1'b0;
    $display("tick");
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] e;
    cyc(); cyc();
    rst_i = 1'b0;
    chk("reset_rdata", reg_rdata_o, 8'h00);
    chk("reset_freq", freq_o, '0);
    chk("reset_fc", fc_o, 11'h000);

    osc3_i = 8'hA5; env3_i = 8'h3C;
    for (int a = 0; a < 128; a++) begin
      rd(7'(a), v);
      e = (a == 27) ? 8'hA5 : (a == 28) ? 8'h3C : 8'h00;
      chk($sformatf("rd_all_%02h", a), v, e);
    end

    wr(7'h00, 8'h34); tick();
    chk("freq0_lo_only", freq_o[0], 16'h0000);
    wr(7'h01, 8'h12); tick();
    chk("freq0_pair", freq_o[0], 16'h1234);

    wr(7'h07, 8'h11); wr(7'h07, 8'h22); wr(7'h08, 8'h99); tick();
    chk("freq1_last_lo", freq_o[1], 16'h9922);
    rd(7'h07, v);
    chk("rd_pending_lo", v, 8'h22);

    wr(7'h12, 8'h01); tick();
    chk("gate_rise_v2", gate_rise_o, 3'b100);
    chk("gate_fall_none", gate_fall_o, 3'b000);
    cyc();
    chk("gate_rise_1cyc", gate_rise_o, 3'b000);
    wr(7'h12, 8'h00); tick();
    chk("gate_fall_v2", gate_fall_o, 3'b100);

    wr(7'h04, 8'h01); wr(7'h04, 8'h00); tick();
    chk("toggle_no_rise", gate_rise_o, 3'b000);
    chk("toggle_no_fall", gate_fall_o, 3'b000);

    reg_addr_i = 7'h16; reg_wdata_i = 8'hFF; reg_we_i = 1'b1; sample_tick_i = 1'b1;
    cyc();
    reg_we_i = 1'b0; sample_tick_i = 1'b0;
    chk("fc_coincident", fc_o, 11'h000);
    tick();
    chk("fc_next_tick", fc_o, 11'h7F8);

    wr(7'h03, 8'hFF); rd(7'h03, v);
    chk("pw_hi_mask", v, 8'h0F);
    wr(7'h1D, 8'h55); rd(7'h1D, v);
    chk("rd_unmapped", v, 8'h00);

    wr(7'h0E, 8'h77);
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    rd(7'h0E, v);
    chk("rst_pending_cleared", v, 8'h00);
    wr(7'h0F, 8'h56); tick();
    chk("rst_mid_pair", freq_o[2], 16'h5600);

    for (int i = 0; i < 4000; i++) begin
      rst_i         = ($urandom_range(0, 499) == 0);
      reg_addr_i    = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 28));
      reg_wdata_i   = 8'($urandom);
      reg_we_i      = 1'($urandom);
      sample_tick_i = ($urandom_range(0, 5) == 0);
      osc3_i        = 8'($urandom);
      env3_i        = 8'($urandom);
      cyc();
    end
    rst_i = 1'b0; reg_we_i = 1'b0; sample_tick_i = 1'b0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
